// File: rtl/timer_ctrl_pkg.sv
// Shared types, widths and small helpers for the two-mode (stopwatch /
// countdown) timer controller.
package timer_ctrl_pkg;

  // Datapath widths.
  localparam int PRESC_W = 25;
  localparam int MIN_W   = 7;
  localparam int SEC_W   = 6;

  // Largest displayable time value, 99:59.
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 7'd99;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counting direction, captured when a run is started from IDLE.
  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_t;

  // Presets beyond the displayable range saturate instead of wrapping.
  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] value);
    return (value > MIN_MAX) ? MIN_MAX : value;
  endfunction

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] value);
    return (value > SEC_MAX) ? SEC_MAX : value;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler for the timer controller. Counts enabled cycles
// and raises a one-cycle wrap strobe on the cycle that returns it to zero.
// A synchronous clear forces the count back to zero and suppresses the
// strobe; while disabled the count is retained.
module tick_prescaler
  import timer_ctrl_pkg::*;
#(
  parameter logic [PRESC_W-1:0] DIV = 25'd25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [PRESC_W-1:0] DIV_LAST = DIV - 1'b1;

  logic [PRESC_W-1:0] count;

  // The wrap strobe is combinational so the time update lands on the very
  // edge where the count returns to zero.
  assign wrap = en && !clr && (count == DIV_LAST);

  // Prescaler count register: clear wins over enable, wrap at DIV-1.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/two_mode_timer_ctrl.sv
// Two-mode timer controller: runs the IDLE/RUN/PAUSE/DONE state machine,
// keeps the mm:ss time value and drives the one-cycle tick for the display.
// Optional feature macro: TIMER_ALARM_EN. When defined, an alarm output is
// raised on entry to DONE and held for ALARM_TICKS tick periods, and the
// prescaler keeps running in DONE. When undefined, alarm is tied low and the
// prescaler is parked at zero in DONE.
module two_mode_timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter logic [PRESC_W-1:0] TICK_DIV = 25'd25_000_000
`ifdef TIMER_ALARM_EN
  ,
  parameter int unsigned ALARM_TICKS = 5
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             mode,
  input  logic             set_en,
  input  logic [MIN_W-1:0] set_min,
  input  logic [SEC_W-1:0] set_sec,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic             alarm
);

  state_t           state, state_nxt;
  mode_t            mode_q, mode_nxt;
  logic [MIN_W-1:0] min_nxt;
  logic [SEC_W-1:0] sec_nxt;
  logic             tick_nxt;
  logic             presc_en;
  logic             presc_clr;
  logic             wrap;
  logic             time_zero;

`ifdef TIMER_ALARM_EN
  localparam logic [2:0] ALARM_LAST = 3'(ALARM_TICKS - 1);

  logic       alarm_q, alarm_nxt;
  logic [2:0] alarm_cnt, alarm_cnt_nxt;
`endif

  assign time_zero = (min == '0) && (sec == '0);

  // Prescaler control: counts in RUN (and in DONE for the alarm build), is
  // held at zero in IDLE and is forced to zero by clear. PAUSE just freezes
  // it so no cycles are lost across a pause/resume.
`ifdef TIMER_ALARM_EN
  assign presc_en  = (state == RUN) || (state == DONE);
  assign presc_clr = clear || (state == IDLE);
`else
  assign presc_en  = (state == RUN);
  assign presc_clr = clear || (state == IDLE) || (state == DONE);
`endif

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .wrap (wrap)
  );

  // Next-state, time arithmetic and alarm decisions.
  // Priority: clear > tick update > start > set_en.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    min_nxt   = min;
    sec_nxt   = sec;
    tick_nxt  = wrap;
`ifdef TIMER_ALARM_EN
    alarm_nxt     = alarm_q;
    alarm_cnt_nxt = alarm_cnt;
`endif

    if (clear) begin
      state_nxt = IDLE;
      min_nxt   = '0;
      sec_nxt   = '0;
`ifdef TIMER_ALARM_EN
      alarm_nxt     = 1'b0;
      alarm_cnt_nxt = '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // A countdown from 00:00 has nothing to do; stay put.
            if (!((mode_t'(mode) == MODE_DOWN) && time_zero)) begin
              state_nxt = RUN;
              mode_nxt  = mode_t'(mode);
            end
          end else if (set_en) begin
            min_nxt = clamp_min(set_min);
            sec_nxt = clamp_sec(set_sec);
          end
        end

        RUN: begin
          if (wrap) begin
            if (mode_q == MODE_UP) begin
              if ((min == MIN_MAX) && (sec == SEC_MAX)) begin
                // Saturate at 99:59 and finish.
                state_nxt = DONE;
              end else if (sec == SEC_MAX) begin
                sec_nxt = '0;
                min_nxt = min + 1'b1;
              end else begin
                sec_nxt = sec + 1'b1;
              end
            end else begin
              if (sec == '0) begin
                sec_nxt = SEC_MAX;
                min_nxt = min - 1'b1;
              end else begin
                sec_nxt = sec - 1'b1;
              end
              // The update that lands on 00:00 finishes on the same edge.
              if ((min_nxt == '0) && (sec_nxt == '0)) begin
                state_nxt = DONE;
              end
            end
`ifdef TIMER_ALARM_EN
            if (state_nxt == DONE) begin
              alarm_nxt     = 1'b1;
              alarm_cnt_nxt = '0;
            end
`endif
          end
          // A start on a non-terminal edge pauses; a terminal tick wins.
          if ((state_nxt == RUN) && start) begin
            state_nxt = PAUSE;
          end
        end

        PAUSE: begin
          if (start) begin
            state_nxt = RUN;
          end
        end

        DONE: begin
`ifdef TIMER_ALARM_EN
          // Count ticks spent in DONE while the alarm is sounding.
          if (wrap && alarm_q) begin
            alarm_cnt_nxt = alarm_cnt + 1'b1;
            if (alarm_cnt == ALARM_LAST) begin
              alarm_nxt = 1'b0;
            end
          end
`endif
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, latched mode, time and tick registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= MODE_UP;
      min    <= '0;
      sec    <= '0;
      tick   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      min    <= min_nxt;
      sec    <= sec_nxt;
      tick   <= tick_nxt;
    end
  end

`ifdef TIMER_ALARM_EN
  // Alarm output and its tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      alarm_q   <= alarm_nxt;
      alarm_cnt <= alarm_cnt_nxt;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  // Status flags decoded straight from the state register.
  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_two_mode_timer_ctrl.sv
// Self-checking bench for two_mode_timer_ctrl with TICK_DIV = 4. A
// behavioural model tracks the time as a plain count of seconds plus a count
// of run cycles since the last tick; every cycle all outputs are compared
// against it, and a few directed scenarios add fixed expected values.
module tb_two_mode_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int T_MAX    = 99 * 60 + 59;
`ifdef TIMER_ALARM_EN
  localparam int ALARM_TICKS = 5;
`endif

  logic       clk = 1'b0;
  logic       rst, start, clear, mode, set_en;
  logic [6:0] set_min;
  logic [5:0] set_sec;
  logic [6:0] min;
  logic [5:0] sec;
  logic       tick, running, done, alarm;

  two_mode_timer_ctrl #(
    .TICK_DIV (25'd4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clear   (clear),
    .mode    (mode),
    .set_en  (set_en),
    .set_min (set_min),
    .set_sec (set_sec),
    .min     (min),
    .sec     (sec),
    .tick    (tick),
    .running (running),
    .done    (done),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;
  mstate_e m_st;
  int      t;       // total seconds on display
  int      phase;   // run cycles since last tick
  bit      m_down;
  bit      e_tick;
  bit      e_alarm;
`ifdef TIMER_ALARM_EN
  int      acount;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic enter_done();
    m_st = M_DONE;
`ifdef TIMER_ALARM_EN
    e_alarm = 1'b1;
    acount  = 0;
`else
    e_alarm = 1'b0;
`endif
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic model_step();
    e_tick = 1'b0;
    if (rst) begin
      m_st = M_IDLE; t = 0; phase = 0; m_down = 1'b0; e_alarm = 1'b0;
    end else if (clear) begin
      m_st = M_IDLE; t = 0; phase = 0; e_alarm = 1'b0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (start) begin
            if (!(mode && t == 0)) begin
              m_st   = M_RUN;
              m_down = mode;
            end
          end else if (set_en) begin
            t = ((set_min > 99) ? 99 : int'(set_min)) * 60
              + ((set_sec > 59) ? 59 : int'(set_sec));
          end
        end
        M_RUN: begin
          phase++;
          if (phase == TICK_DIV) begin
            phase  = 0;
            e_tick = 1'b1;
            if (!m_down) begin
              if (t == T_MAX) enter_done();
              else t++;
            end else begin
              t--;
              if (t == 0) enter_done();
            end
          end
          if (m_st == M_RUN && start) m_st = M_PAUSE;
        end
        M_PAUSE: begin
          if (start) m_st = M_RUN;
        end
        M_DONE: begin
`ifdef TIMER_ALARM_EN
          phase++;
          if (phase == TICK_DIV) begin
            phase  = 0;
            e_tick = 1'b1;
            if (e_alarm) begin
              acount++;
              if (acount == ALARM_TICKS) e_alarm = 1'b0;
            end
          end
`endif
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  // One clock: inputs already driven; step model at the edge, compare
  // outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("min",     min,     t / 60);
    check("sec",     sec,     t % 60);
    check("tick",    tick,    e_tick);
    check("running", running, m_st == M_RUN);
    check("done",    done,    m_st == M_DONE);
    check("alarm",   alarm,   e_alarm);
  endtask

  task automatic drive(input logic r, input logic s, input logic c, input logic m,
                       input logic se, input logic [6:0] sm, input logic [5:0] ss);
    rst = r; start = s; clear = c; mode = m; set_en = se; set_min = sm; set_sec = ss;
    step();
    rst = 1'b0; start = 1'b0; clear = 1'b0; set_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, mode, 1'b0, set_min, set_sec);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; mode = 1'b0; set_en = 1'b0;
    set_min = '0; set_sec = '0;
    m_st = M_IDLE; t = 0; phase = 0; m_down = 1'b0; e_tick = 1'b0; e_alarm = 1'b0;
    @(negedge clk);

    // Reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    check("reset_outputs", {min, sec, tick, running, done, alarm}, 32'd0);

    // Up-count: tick every 4 cycles, 00:01, 00:02 ... 01:00.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    check("up_running_after_start", running, 1'b1);
    idle(3);
    check("up_no_tick_yet", {tick, sec}, {1'b0, 6'd0});
    idle(1);
    check("up_first_tick", {tick, sec}, {1'b1, 6'd1});
    idle(4);
    check("up_second_tick", {tick, sec}, {1'b1, 6'd2});
    idle(232);
    check("up_after_60_ticks", {min, sec}, {7'd1, 6'd0});

    // Countdown to zero from 00:02.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    check("clear_to_idle", {running, min, sec}, 14'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 6'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 6'd2);
    idle(4);
    check("down_first", {min, sec, done}, {7'd0, 6'd1, 1'b0});
    idle(4);
    check("down_terminal", {min, sec, tick, done, running}, {7'd0, 6'd0, 1'b1, 1'b1, 1'b0});
    idle(3);
    check("down_hold", {min, sec, done}, {7'd0, 6'd0, 1'b1});

    // Pause and resume keep the partial prescaler count.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    check("paused", running, 1'b0);
    idle(10);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    idle(1);
    check("resume_no_tick", {tick, sec}, {1'b0, 6'd0});
    idle(1);
    check("resume_tick", {tick, sec}, {1'b1, 6'd1});

    // Saturation at 99:59, alarm window in the alarm build.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd99, 6'd59);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd99, 6'd59);
    idle(4);
    check("saturate", {min, sec, done}, {7'd99, 6'd59, 1'b1});
`ifdef TIMER_ALARM_EN
    check("alarm_with_done", alarm, 1'b1);
`endif
    idle(24);
    check("alarm_dropped_done_held", {alarm, done}, {1'b0, 1'b1});

    // Clear beats start while running.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0);
    idle(5);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
    check("clear_priority", {running, done, min, sec}, 15'd0);

    // Zero countdown refused; preset clamping.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 6'd0);
    check("zero_countdown_idle", {running, done}, 2'b00);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd120, 6'd63);
    check("clamp_preset", {min, sec}, {7'd99, 6'd59});

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 999) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            7'($urandom_range(0, 127)),
            6'($urandom_range(0, 63)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
